// File: rtl/crc_7_if.sv
`default_nettype none
// ============================================================================
//  Module  : crc_7_if
//  Purpose : Serial data / enable / remainder bundle between the SD command
//            host and the CRC7 block. The CRC_ZERO residue flag is present
//            only when CRC7_ZERO_FLAG_EN is defined.
//  Rev     : 1.0  initial release
// ============================================================================
interface crc_7_if #(
  parameter int WIDTH = 7
);
  logic             BITVAL;
  logic             ENABLE;
  logic [WIDTH-1:0] CRC;
`ifdef CRC7_ZERO_FLAG_EN
  logic             CRC_ZERO;

  modport master (output BITVAL, output ENABLE, input  CRC, input  CRC_ZERO);
  modport slave  (input  BITVAL, input  ENABLE, output CRC, output CRC_ZERO);
`else
  modport master (output BITVAL, output ENABLE, input  CRC);
  modport slave  (input  BITVAL, input  ENABLE, output CRC);
`endif
endinterface
`default_nettype wire

// File: rtl/crc_7.sv
`default_nettype none
// ============================================================================
//  Module  : crc_7
//  Purpose : Bit-serial CRC7 (x^7 + x^3 + 1) generator/checker for the SD
//            CMD line. Message bits are shifted in MSB-first whenever ENABLE
//            is high; CRC is a direct register output, CRC[6] goes out first.
//  Options : CRC7_ZERO_FLAG_EN - adds CRC_ZERO = (CRC == 0) for residue checks.
//  Rev     : 1.0  initial release
// ============================================================================
module crc_7 #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] POLY  = 7'h09,
  parameter logic [WIDTH-1:0] INIT  = 7'h00
) (
  input  logic     CLK,
  input  logic     RST,
  crc_7_if.slave   bus
);

  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_d;
  logic             fb;

  // Next remainder: one LFSR step when enabled, otherwise hold. BITVAL is
  // only looked at under ENABLE so an undriven line during gaps is harmless.
  always_comb begin
    crc_d = crc_q;
    fb    = 1'b0;
    if (bus.ENABLE) begin
      fb       = bus.BITVAL ^ crc_q[WIDTH-1];
      crc_d[0] = fb;
      for (int i = 1; i < WIDTH; i++) begin
        crc_d[i] = crc_q[i-1] ^ (fb & POLY[i]);
      end
    end
  end

  // Remainder register; reset clears it immediately and wins over ENABLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign bus.CRC = crc_q;

`ifdef CRC7_ZERO_FLAG_EN
  assign bus.CRC_ZERO = (crc_q == '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc_7.sv
`default_nettype none
// ============================================================================
//  Module  : tb_crc_7
//  Purpose : Self-checking bench for crc_7. Expected remainders come from a
//            polynomial long-division model (message * x^7 mod 0x89) and
//            from the published SD command CRC constants.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_crc_7;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;

  crc_7_if #(.WIDTH(7)) bus_if ();

  crc_7 u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Reference: remainder of M(x)*x^7 divided by x^7+x^3+1, by long division.
  function automatic logic [6:0] crc_ref(input logic [63:0] msg, input int n);
    logic [127:0] r;
    r = {64'd0, msg} << 7;
    for (int i = n + 6; i >= 7; i--) begin
      if (r[i]) r = r ^ (128'h89 << (i - 7));
    end
    return r[6:0];
  endfunction

  // Present one bit, optionally preceded by 1..gap_max disabled cycles with
  // random BITVAL. Returns #1 after the enabled rising edge.
  task automatic send_bit(input logic b, input int gap_max);
    int gaps;
    gaps = (gap_max > 0) ? $urandom_range(gap_max, 1) : 0;
    repeat (gaps) begin
      @(negedge CLK);
      bus_if.ENABLE = 1'b0;
      bus_if.BITVAL = 1'($urandom);
    end
    @(negedge CLK);
    bus_if.ENABLE = 1'b1;
    bus_if.BITVAL = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_msg(input logic [63:0] msg, input int n, input int gap_max);
    for (int i = n - 1; i >= 0; i--) send_bit(msg[i], gap_max);
    @(negedge CLK);
    bus_if.ENABLE = 1'b0;
    bus_if.BITVAL = 1'($urandom);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic check_zero_flag(input string tag, input logic exp);
`ifdef CRC7_ZERO_FLAG_EN
    check(tag, {6'd0, bus_if.CRC_ZERO}, {6'd0, exp});
`endif
  endtask

  logic [63:0] msg;
  logic [6:0]  exp;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST           = 1'b1;
    bus_if.ENABLE = 1'b0;
    bus_if.BITVAL = 1'b0;
    #1;
    check("reset_initial", bus_if.CRC, 7'h00);
    check_zero_flag("zflag_reset", 1'b1);
    @(negedge CLK);
    RST = 1'b0;

    // Asynchronous reset with a nonzero remainder, then held over 3 edges.
    send_msg(64'h48_0000_01AA >> 20, 20, 0);
    check("partial_cmd8", bus_if.CRC, crc_ref(64'h48_0000_01AA >> 20, 20));
    #2;
    RST = 1'b1;
    #1;
    check("async_reset", bus_if.CRC, 7'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      bus_if.ENABLE = 1'b1;
      bus_if.BITVAL = 1'(k == 1 ? 0 : 1);
      @(posedge CLK);
      #1;
      check("reset_hold", bus_if.CRC, 7'h00);
    end
    @(negedge CLK);
    bus_if.ENABLE = 1'b0;
    RST = 1'b0;

    // Known SD command vectors.
    send_msg(64'h40_0000_0000, 40, 0);
    check("cmd0", bus_if.CRC, 7'h4A);
    repeat (3) @(negedge CLK);
    check("cmd0_hold", bus_if.CRC, 7'h4A);
    pulse_reset();
    send_msg(64'h48_0000_01AA, 40, 0);
    check("cmd8", bus_if.CRC, 7'h43);
    pulse_reset();
    send_msg(64'h51_0000_0000, 40, 0);
    check("cmd17", bus_if.CRC, 7'h2A);

    // ENABLE gaps must not change the result.
    for (int k = 0; k < 3; k++) begin
      pulse_reset();
      send_msg(64'h48_0000_01AA, 40, 5);
      check("cmd8_gaps", bus_if.CRC, 7'h43);
    end

    // Residue: message followed by its own CRC leaves zero.
    pulse_reset();
    send_msg({17'd0, 40'h40_0000_0000, 7'b1001010}, 47, 0);
    check("residue_ok", bus_if.CRC, 7'h00);
    check_zero_flag("zflag_ok", 1'b1);
    pulse_reset();
    msg = {17'd0, 40'h40_0000_0000, 7'b1001010} ^ (64'd1 << 20);
    send_msg(msg, 47, 0);
    check("residue_bad", {6'd0, bus_if.CRC != 7'h00}, 7'h01);
    check("residue_bad_val", bus_if.CRC, crc_ref(msg, 47));
    check_zero_flag("zflag_bad", 1'b0);

    // Reset mid-stream discards the partial remainder.
    pulse_reset();
    send_msg(64'h48_0000_01AA >> 20, 20, 0);
    pulse_reset();
    send_msg(64'h40_0000_0000, 40, 0);
    check("midstream_reset", bus_if.CRC, 7'h4A);

    // Random messages, with and without gaps, plus their residues.
    for (int k = 0; k < 8; k++) begin
      msg = {24'd0, 8'($urandom), 32'($urandom)};
      pulse_reset();
      send_msg(msg, 40, (k % 2 == 1) ? 3 : 0);
      exp = crc_ref(msg, 40);
      check("random_msg", bus_if.CRC, exp);
      pulse_reset();
      send_msg({msg[56:0], exp}, 47, 0);
      check("random_residue", bus_if.CRC, 7'h00);
      check_zero_flag("zflag_random", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
